config_frame_decoder: RTL and testbench
=======================================

Name: config_frame_decoder

Overview:
- Consumer end of the 32-bit word/strobe configuration stream that the USB controller drives as efpga_write_data/efpga_write_strobe.
- Hunts for a sync word, then decodes frame-address words and row-data words into a frame register, a one-hot frame-select vector and a commit strobe for the fabric configuration columns.
- Sits between the controller and the fabric frame-data/frame-select nets, in the clk_system_i domain.

Parameters:
- NUMBER_OF_ROWS, 4, fabric rows; also the number of data words per frame.
- NUMBER_OF_COLS, 5, fabric columns.
- FRAME_BITS_PER_ROW, 32, bits per data word; fixed at 32.
- MAX_FRAMES_PER_COL, 20, frames per column.
- DESYNC_FLAG, 20, bit position of the desync flag in the address word.
- FRAME_SELECT_WIDTH, 5, width of the frame index field.
- SYNC_WORD, 32'hFAB0_FAB1, stream synchronisation pattern.

Ports:
- clk_system_i  in  1  system clock; single clock domain.
- reset_n_i  in  1  asynchronous, active-low reset.
- write_data_i  in  32  configuration word; valid only when write_strobe_i=1.
- write_strobe_i  in  1  one-cycle word-valid qualifier; no backpressure.
- frame_data_o  out  NUMBER_OF_ROWS*FRAME_BITS_PER_ROW  assembled frame; held stable after commit.
- frame_select_o  out  MAX_FRAMES_PER_COL*NUMBER_OF_COLS  one-hot select, valid only while frame_strobe_o=1; otherwise 0.
- frame_strobe_o  out  1  one-cycle frame commit pulse.
- synced_o  out  1  high between a sync and a desync.
- error_o  out  1  sticky: address out of range; cleared only by reset or the next sync word.

Behaviour:
- Reset (async assert, sync release): state=HUNT; all outputs 0; frame_data_o=0; word counter=0.
- Words are consumed only on cycles with write_strobe_i=1. Idle cycles between words are unlimited and never change state.
- HUNT:
  - Strobed word == SYNC_WORD -> ADDR; synced_o=1; error_o=0.
  - Any other word -> ignored; stay in HUNT.
- ADDR, strobed word A:
  - A[DESYNC_FLAG]=1 -> HUNT; synced_o=0; no frame is produced. Desync takes priority over the range check.
  - Otherwise latch col=A[31:24] and frame=A[FRAME_SELECT_WIDTH-1:0].
  - The frame is valid iff col<NUMBER_OF_COLS and frame<MAX_FRAMES_PER_COL. If invalid, set error_o.
  - In both cases -> DATA with counter=0.
- DATA, strobed word:
  - Shift the word into the frame shift register: reg = {reg[(N-1)*32-1:0], word}. The first data word ends in the MSB slice; the last data word ends in [31:0].
  - Increment the counter. On the word with counter==NUMBER_OF_ROWS-1 -> ADDR.
  - If that frame was valid, frame_strobe_o=1 on the next cycle, with frame_select_o bit (col*MAX_FRAMES_PER_COL+frame) set for that same cycle only.
  - If the frame was invalid, the data words are consumed with no strobe.
  - frame_data_o is the frame register; it updates on each data word.
- Latency: last data word strobed in cycle N -> frame_strobe_o in cycle N+1.
  - A strobe in cycle N+1 is already decoded as the next address word, so back-to-back frames lose nothing.
- SYNC_WORD seen in ADDR or DATA: treated as ordinary data or an address (no resync). Resync requires a desync first.
- Reset mid-frame: the partial frame is discarded; no strobe is produced; state returns to HUNT.
- Width rules: column index math uses a $clog2(MAX_FRAMES_PER_COL*NUMBER_OF_COLS)-bit product. Out-of-range bits never index frame_select_o.

Decomposition:
- Package config_frame_pkg holds:
  - the state enum (HUNT, ADDR, DATA);
  - SYNC_WORD;
  - the address field positions (COL_MSB=31, COL_LSB=24).
- No sub-module is required. The decoder is one FSM plus a shift register and a one-hot generator. The one-hot generator may be a function in the package.

Test Plan:
- Reset, then strobe 0xFAB0_FAB1 -> synced_o=1 next cycle; error_o=0; frame_strobe_o stays 0.
- Sync, addr 0x0200_0003, data 0x11111111, 0x22222222, 0x33333333, 0x44444444 -> one frame_strobe_o pulse one cycle after the last word.
  - frame_data_o = 0x11111111_22222222_33333333_44444444.
  - Only frame_select_o bit 43 set (col 2 × 20 + frame 3).
- Two back-to-back frames with the strobe asserted every cycle -> exactly two strobe pulses, 5 cycles apart, with the correct selects.
- Addr 0x0700_0001 (col 7 ≥ 5), then 4 data words -> error_o=1 and no strobe. The next valid frame still commits, and error_o stays 1.
- Addr 0x0010_0000 (bit 20 set) -> synced_o=0. A following addr-like word and 4 data words produce no strobe until a new sync.
- Assert reset_n_i after data word 2 of a frame -> all outputs 0 immediately. After release, the remaining words are ignored in HUNT.

Source files
------------

// File: rtl/config_frame_pkg.sv
// Shared types and constants for the configuration frame decoder.
package config_frame_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  localparam logic [31:0] SYNC_WORD = 32'hFAB0_FAB1;

  // Column field position inside an address word.
  localparam int unsigned COL_MSB = 31;
  localparam int unsigned COL_LSB = 24;

endpackage

// File: rtl/config_frame_decoder.sv
// Decodes the controller's word/strobe configuration stream into fabric frame
// data, a one-hot frame select and a one-cycle commit strobe.
module config_frame_decoder
  import config_frame_pkg::*;
#(
  parameter int unsigned NUMBER_OF_ROWS     = 4,
  parameter int unsigned NUMBER_OF_COLS     = 5,
  parameter int unsigned FRAME_BITS_PER_ROW = 32,
  parameter int unsigned MAX_FRAMES_PER_COL = 20,
  parameter int unsigned DESYNC_FLAG        = 20,
  parameter int unsigned FRAME_SELECT_WIDTH = 5
) (
  input  logic                                         clk_system_i,
  input  logic                                         reset_n_i,
  input  logic [31:0]                                  write_data_i,
  input  logic                                         write_strobe_i,
  output logic [NUMBER_OF_ROWS*FRAME_BITS_PER_ROW-1:0] frame_data_o,
  output logic [MAX_FRAMES_PER_COL*NUMBER_OF_COLS-1:0] frame_select_o,
  output logic                                         frame_strobe_o,
  output logic                                         synced_o,
  output logic                                         error_o
);

  localparam int unsigned DATA_W = NUMBER_OF_ROWS * FRAME_BITS_PER_ROW;
  localparam int unsigned SEL_W  = MAX_FRAMES_PER_COL * NUMBER_OF_COLS;
  localparam int unsigned IDX_W  = $clog2(SEL_W);
  localparam int unsigned CNT_W  = (NUMBER_OF_ROWS > 1) ? $clog2(NUMBER_OF_ROWS) : 1;
  localparam int unsigned COL_W  = COL_MSB - COL_LSB + 1;
  localparam int unsigned FRM_W  = FRAME_SELECT_WIDTH;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [FRM_W-1:0]    frm_q, frm_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   data_d;
  logic [SEL_W-1:0]    sel_d;
  logic                strobe_d, synced_d, error_d;

  logic [COL_W-1:0]    addr_col;
  logic [FRM_W-1:0]    addr_frm;
  logic                addr_ok;
  logic [IDX_W-1:0]    commit_idx;
  logic [SEL_W-1:0]    commit_sel;

  // Address field decode and range check on the incoming word.
  assign addr_col = write_data_i[COL_MSB:COL_LSB];
  assign addr_frm = write_data_i[FRM_W-1:0];
  assign addr_ok  = (32'(addr_col) < NUMBER_OF_COLS) && (32'(addr_frm) < MAX_FRAMES_PER_COL);

  // Flat select index; only meaningful (and only used) for a range-checked frame.
  assign commit_idx = IDX_W'(col_q) * IDX_W'(MAX_FRAMES_PER_COL) + IDX_W'(frm_q);

  always_comb begin
    commit_sel = '0;
    for (int unsigned i = 0; i < SEL_W; i++) begin
      commit_sel[i] = (commit_idx == IDX_W'(i));
    end
  end

  always_ff @(posedge clk_system_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q        <= HUNT;
      cnt_q          <= '0;
      col_q          <= '0;
      frm_q          <= '0;
      valid_q        <= 1'b0;
      frame_data_o   <= '0;
      frame_select_o <= '0;
      frame_strobe_o <= 1'b0;
      synced_o       <= 1'b0;
      error_o        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      col_q          <= col_d;
      frm_q          <= frm_d;
      valid_q        <= valid_d;
      frame_data_o   <= data_d;
      frame_select_o <= sel_d;
      frame_strobe_o <= strobe_d;
      synced_o       <= synced_d;
      error_o        <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    col_d    = col_q;
    frm_d    = frm_q;
    valid_d  = valid_q;
    data_d   = frame_data_o;
    synced_d = synced_o;
    error_d  = error_o;
    strobe_d = 1'b0;
    sel_d    = '0;

    if (write_strobe_i) begin
      unique case (state_q)
        HUNT: begin
          if (write_data_i == SYNC_WORD) begin
            state_d  = ADDR;
            synced_d = 1'b1;
            error_d  = 1'b0;
          end
        end
        ADDR: begin
          // Desync wins over the range check.
          if (write_data_i[DESYNC_FLAG]) begin
            state_d  = HUNT;
            synced_d = 1'b0;
          end else begin
            col_d   = addr_col;
            frm_d   = addr_frm;
            valid_d = addr_ok;
            cnt_d   = '0;
            state_d = DATA;
            if (!addr_ok) begin
              error_d = 1'b1;
            end
          end
        end
        DATA: begin
          data_d = {frame_data_o[DATA_W-FRAME_BITS_PER_ROW-1:0], write_data_i};
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NUMBER_OF_ROWS - 1)) begin
            state_d = ADDR;
            if (valid_q) begin
              strobe_d = 1'b1;
              sel_d    = commit_sel;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_config_frame_decoder.sv
// Directed plus randomized checks of config_frame_decoder against a word-level stream model.
module tb_config_frame_decoder;

  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

  logic          clk_system_i;
  logic          reset_n_i;
  logic [31:0]   write_data_i;
  logic          write_strobe_i;
  logic [127:0]  frame_data_o;
  logic [99:0]   frame_select_o;
  logic          frame_strobe_o;
  logic          synced_o;
  logic          error_o;

  config_frame_decoder dut (
    .clk_system_i   (clk_system_i),
    .reset_n_i      (reset_n_i),
    .write_data_i   (write_data_i),
    .write_strobe_i (write_strobe_i),
    .frame_data_o   (frame_data_o),
    .frame_select_o (frame_select_o),
    .frame_strobe_o (frame_strobe_o),
    .synced_o       (synced_o),
    .error_o        (error_o)
  );

  initial clk_system_i = 1'b0;
  always #5 clk_system_i = ~clk_system_i;

  int n_cmp = 0;
  int n_bad = 0;

  // Stream model: sync status, whether an address is due, last four data words.
  bit          m_synced;
  bit          m_need_addr;
  bit          m_ok;
  bit          m_error;
  bit          exp_strobe;
  int          m_idx;
  int          m_nwords;
  logic [31:0] hist[$];

  task automatic model_reset();
    m_synced    = 0;
    m_need_addr = 0;
    m_ok        = 0;
    m_error     = 0;
    exp_strobe  = 0;
    m_idx       = 0;
    m_nwords    = 0;
    hist.delete();
    for (int i = 0; i < 4; i++) hist.push_back(32'h0);
  endtask

  task automatic model_word(input logic s, input logic [31:0] w);
    int col;
    int fr;
    exp_strobe = 0;
    if (!s) return;
    if (!m_synced) begin
      if (w == SYNC) begin
        m_synced    = 1;
        m_error     = 0;
        m_need_addr = 1;
      end
    end else if (m_need_addr) begin
      if (w[20]) begin
        m_synced = 0;
      end else begin
        col         = int'(w[31:24]);
        fr          = int'(w[4:0]);
        m_ok        = (col < 5) && (fr < 20);
        if (!m_ok) m_error = 1;
        m_idx       = col * 20 + fr;
        m_nwords    = 0;
        m_need_addr = 0;
      end
    end else begin
      hist.push_back(w);
      void'(hist.pop_front());
      m_nwords++;
      if (m_nwords == 4) begin
        exp_strobe  = m_ok;
        m_need_addr = 1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    logic [99:0]  es;
    logic [127:0] ed;
    es = '0;
    if (exp_strobe) es[m_idx] = 1'b1;
    ed = {hist[0], hist[1], hist[2], hist[3]};
    check({tag, "/strobe"}, 128'(frame_strobe_o), 128'(exp_strobe));
    check({tag, "/select"}, 128'(frame_select_o), 128'(es));
    check({tag, "/synced"}, 128'(synced_o), 128'(m_synced));
    check({tag, "/error"},  128'(error_o), 128'(m_error));
    check({tag, "/data"},   frame_data_o, ed);
  endtask

  task automatic step(input string tag, input logic s, input logic [31:0] w);
    @(negedge clk_system_i);
    write_strobe_i = s;
    write_data_i   = w;
    @(posedge clk_system_i);
    #1;
    model_word(s, w);
    compare_all(tag);
  endtask

  task automatic frame(input string tag, input logic [31:0] addr);
    step(tag, 1'b1, addr);
    for (int i = 0; i < 4; i++) step(tag, 1'b1, $urandom);
  endtask

  initial begin
    logic [99:0]  bit43;
    logic [31:0]  w;
    int           pick;

    bit43          = 100'(1) << 43;
    reset_n_i      = 1'b1;
    write_strobe_i = 1'b0;
    write_data_i   = 32'h0;
    model_reset();
    #3 reset_n_i = 1'b0;
    repeat (2) @(posedge clk_system_i);
    #1 compare_all("reset");
    @(negedge clk_system_i);
    reset_n_i = 1'b1;

    // Sync acquisition, with a junk word first.
    step("hunt_junk", 1'b1, 32'h1234_5678);
    step("sync", 1'b1, SYNC);
    step("idle", 1'b0, SYNC);

    // Single valid frame: col 2, frame 3.
    step("f1_addr", 1'b1, 32'h0200_0003);
    step("f1_d0", 1'b1, 32'h1111_1111);
    step("f1_d1", 1'b1, 32'h2222_2222);
    step("f1_d2", 1'b1, 32'h3333_3333);
    step("f1_d3", 1'b1, 32'h4444_4444);
    check("f1_const_data", frame_data_o, 128'h11111111_22222222_33333333_44444444);
    check("f1_const_sel", 128'(frame_select_o), 128'(bit43));

    // Back-to-back frames, no idle cycles.
    frame("b2b_a", 32'h0400_0013);
    frame("b2b_b", 32'h0000_0000);
    step("b2b_idle", 1'b0, 32'h0);

    // Out-of-range column, then a valid frame; error stays set.
    frame("bad_col", 32'h0700_0001);
    frame("bad_frm", 32'h0100_0014);
    frame("after_bad", 32'h0300_0005);

    // Desync, then an address-like word and data are ignored.
    step("desync", 1'b1, 32'h0010_0000);
    frame("dead", 32'h0100_0001);
    step("resync", 1'b1, SYNC);
    frame("sync_as_data", 32'h0100_0002);
    step("sync_as_addr", 1'b1, SYNC);
    for (int i = 0; i < 4; i++) step("sync_addr_data", 1'b1, $urandom);

    // Reset in the middle of a frame.
    step("rst_addr", 1'b1, 32'h0100_0002);
    step("rst_d0", 1'b1, 32'hAAAA_0000);
    step("rst_d1", 1'b1, 32'hBBBB_1111);
    @(negedge clk_system_i);
    reset_n_i      = 1'b0;
    write_strobe_i = 1'b0;
    #1;
    model_reset();
    compare_all("rst_mid");
    @(negedge clk_system_i);
    reset_n_i = 1'b1;
    step("rst_d2", 1'b1, 32'hCCCC_2222);
    step("rst_d3", 1'b1, 32'hDDDD_3333);

    // Randomized stream driven by the model's view of what is due next.
    for (int n = 0; n < 600; n++) begin
      pick = int'($urandom_range(0, 99));
      w    = $urandom;
      if (pick < 20) begin
        step("rnd_idle", 1'b0, w);
      end else if (!m_synced) begin
        step("rnd_hunt", 1'b1, (pick < 75) ? SYNC : w);
      end else if (m_need_addr) begin
        w[31:24] = 8'($urandom_range(0, 6));
        w[4:0]   = 5'($urandom_range(0, 23));
        w[20]    = (pick < 28);
        step("rnd_addr", 1'b1, w);
      end else begin
        step("rnd_data", 1'b1, (pick > 95) ? SYNC : w);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
